spi_ram_ctrl: RTL and testbench

- Memory stage directly downstream of the SPI slave FSM (IDLE/CHK_CMD/WRITE/READ_ADD/READ_DATA).
- Consumes each 10-bit word the slave assembles (din[9:8] = command, din[7:0] = payload) when rx_valid is high.
- Maintains separate write and read address pointers over a single-port byte RAM.
- Returns read data to the slave as dout with a one-cycle tx_valid pulse, which the slave serialises onto MISO.

---
 rtl/spi_ram_ctrl.sv | 78 +++++++
 tb/tb_spi_ram_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// Memory stage behind the SPI slave: decodes 10-bit command words into
// write/read pointer updates and byte RAM accesses, and returns read data with a tx_valid pulse.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           din,
    input  logic                 rx_valid,
    output logic [7:0]           dout,
    output logic                 tx_valid,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE-1:0] rd_addr
);

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE:0]   DEPTH_W = MEM_DEPTH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [7:0] mem [0:MEM_DEPTH-1];

    cmd_e                 cmd;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic [ADDR_SIZE-1:0] wr_next;
    logic [ADDR_SIZE-1:0] rd_next;

    assign cmd         = cmd_e'(din[9:8]);
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

    // Pointers wrap at the last real location, not at the pointer width.
    assign wr_next = (wr_addr == LAST) ? '0 : wr_addr + ADDR_SIZE'(1);
    assign rd_next = (rd_addr == LAST) ? '0 : rd_addr + ADDR_SIZE'(1);

    // RAM array has no reset; writes are gated by reset so reset always wins.
    always_ff @(posedge clk) begin
        if (rst_n && rx_valid && cmd == WR_DATA && wr_in_range) begin
            mem[wr_addr[IDX_W-1:0]] <= din[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout     <= 8'h00;
            tx_valid <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
                    WR_DATA: begin
                        if (AUTO_INC != 0) wr_addr <= wr_next;
                    end
                    RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0];
                    RD_DATA: begin
                        dout     <= rd_in_range ? mem[rd_addr[IDX_W-1:0]] : 8'h00;
                        tx_valid <= 1'b1;
                        if (AUTO_INC != 0) rd_addr <= rd_next;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: a vector table on the full-size auto-increment
// instance, plus hand sequences on a 16-deep instance and a non-incrementing one.
module tb_spi_ram_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;

    logic [7:0] dout_a,  wr_a,  rd_a;
    logic       tx_a;
    logic [7:0] dout_s,  wr_s,  rd_s;
    logic       tx_s;
    logic [7:0] dout_n,  wr_n,  rd_n;
    logic       tx_n;

    int checks = 0;
    int errors = 0;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_a), .tx_valid(tx_a), .wr_addr(wr_a), .rd_addr(rd_a)
    );

    spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_SIZE(8), .AUTO_INC(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_s), .tx_valid(tx_s), .wr_addr(wr_s), .rd_addr(rd_s)
    );

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut_noinc (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_n), .tx_valid(tx_n), .wr_addr(wr_n), .rd_addr(rd_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       rx_valid;
        logic [9:0] din;
        logic [7:0] dout;
        logic       tx;
        logic [7:0] wr;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] w(input logic [1:0] cmd, input logic [7:0] b);
        return {cmd, b};
    endfunction

    function automatic void addVec(input logic r, input logic v, input logic [9:0] d,
                                   input logic [7:0] edout, input logic etx,
                                   input logic [7:0] ewr, input logic [7:0] erd);
        vec_t t;
        t.rst_n = r; t.rx_valid = v; t.din = d;
        t.dout = edout; t.tx = etx; t.wr = ewr; t.rd = erd;
        vecs.push_back(t);
    endfunction

    // Drive one cycle of inputs, then let outputs settle just after the edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [9:0] d);
        rst_n    = r;
        rx_valid = v;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkSmall(input string name, input logic [7:0] edout, input logic etx,
                              input logic [7:0] ewr, input logic [7:0] erd);
        checkOutput({name, " dout"}, 32'(dout_s), 32'(edout));
        checkOutput({name, " tx"},   32'(tx_s),   32'(etx));
        checkOutput({name, " wr"},   32'(wr_s),   32'(ewr));
        checkOutput({name, " rd"},   32'(rd_s),   32'(erd));
    endtask

    task automatic checkNoinc(input string name, input logic [7:0] edout, input logic etx,
                              input logic [7:0] ewr, input logic [7:0] erd);
        checkOutput({name, " dout"}, 32'(dout_n), 32'(edout));
        checkOutput({name, " tx"},   32'(tx_n),   32'(etx));
        checkOutput({name, " wr"},   32'(wr_n),   32'(ewr));
        checkOutput({name, " rd"},   32'(rd_n),   32'(erd));
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; din = '0;

        // reset held with a RD_DATA on the bus
        addVec(0, 1, w(3, 8'h00), 8'h00, 0, 8'h00, 8'h00);
        addVec(0, 1, w(3, 8'h00), 8'h00, 0, 8'h00, 8'h00);
        // basic write then read back
        addVec(1, 1, w(0, 8'h2A), 8'h00, 0, 8'h2A, 8'h00);
        addVec(1, 1, w(1, 8'hA5), 8'h00, 0, 8'h2B, 8'h00);
        addVec(1, 1, w(2, 8'h2A), 8'h00, 0, 8'h2B, 8'h2A);
        addVec(1, 1, w(3, 8'h00), 8'hA5, 1, 8'h2B, 8'h2B);
        addVec(1, 0, w(3, 8'h00), 8'hA5, 0, 8'h2B, 8'h2B);
        // back-to-back reads with auto-increment
        addVec(1, 1, w(0, 8'h03), 8'hA5, 0, 8'h03, 8'h2B);
        addVec(1, 1, w(1, 8'h11), 8'hA5, 0, 8'h04, 8'h2B);
        addVec(1, 1, w(1, 8'h22), 8'hA5, 0, 8'h05, 8'h2B);
        addVec(1, 1, w(2, 8'h03), 8'hA5, 0, 8'h05, 8'h03);
        addVec(1, 1, w(3, 8'hFF), 8'h11, 1, 8'h05, 8'h04);
        addVec(1, 1, w(3, 8'h00), 8'h22, 1, 8'h05, 8'h05);
        addVec(1, 0, w(1, 8'h77), 8'h22, 0, 8'h05, 8'h05);
        // read immediately after write to the same address
        addVec(1, 1, w(0, 8'h80), 8'h22, 0, 8'h80, 8'h05);
        addVec(1, 1, w(2, 8'h80), 8'h22, 0, 8'h80, 8'h80);
        addVec(1, 1, w(1, 8'h5A), 8'h22, 0, 8'h81, 8'h80);
        addVec(1, 1, w(3, 8'h00), 8'h5A, 1, 8'h81, 8'h81);
        // reset in the middle of a read, and a write masked by reset
        addVec(1, 1, w(0, 8'h00), 8'h5A, 0, 8'h00, 8'h81);
        addVec(1, 1, w(1, 8'hC3), 8'h5A, 0, 8'h01, 8'h81);
        addVec(1, 1, w(2, 8'h40), 8'h5A, 0, 8'h01, 8'h40);
        addVec(0, 0, w(3, 8'h00), 8'h00, 0, 8'h00, 8'h00);
        addVec(0, 1, w(1, 8'hEE), 8'h00, 0, 8'h00, 8'h00);
        addVec(1, 1, w(3, 8'h00), 8'hC3, 1, 8'h00, 8'h01);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].rx_valid, vecs[i].din);
            checkOutput($sformatf("v%0d dout", i), 32'(dout_a), 32'(vecs[i].dout));
            checkOutput($sformatf("v%0d tx", i),   32'(tx_a),   32'(vecs[i].tx));
            checkOutput($sformatf("v%0d wr", i),   32'(wr_a),   32'(vecs[i].wr));
            checkOutput($sformatf("v%0d rd", i),   32'(rd_a),   32'(vecs[i].rd));
        end

        // 16-deep instance: wrap at MEM_DEPTH-1 and out-of-range accesses
        applyStimulus(0, 0, '0);
        checkSmall("s_rst", 8'h00, 0, 8'h00, 8'h00);
        applyStimulus(1, 1, w(0, 8'h0F));
        checkOutput("s_wr15", 32'(wr_s), 32'h0F);
        applyStimulus(1, 1, w(1, 8'h7E));
        checkOutput("s_wrap", 32'(wr_s), 32'h00);
        applyStimulus(1, 1, w(1, 8'h3C));
        checkOutput("s_wr1", 32'(wr_s), 32'h01);
        applyStimulus(1, 1, w(0, 8'h04));
        applyStimulus(1, 1, w(1, 8'h44));
        applyStimulus(1, 1, w(2, 8'h0F));
        applyStimulus(1, 1, w(3, 8'h00));
        checkSmall("s_rd15", 8'h7E, 1, 8'h05, 8'h00);
        applyStimulus(1, 1, w(3, 8'h00));
        checkSmall("s_rd0", 8'h3C, 1, 8'h05, 8'h01);
        applyStimulus(1, 1, w(0, 8'h14));
        applyStimulus(1, 1, w(1, 8'hFF));
        applyStimulus(1, 1, w(2, 8'h14));
        checkOutput("s_rd20_tx", 32'(tx_s), 32'h0);
        applyStimulus(1, 1, w(3, 8'h00));
        checkOutput("s_oor_dout", 32'(dout_s), 32'h00);
        checkOutput("s_oor_tx",   32'(tx_s),   32'h1);
        applyStimulus(1, 1, w(2, 8'h04));
        applyStimulus(1, 1, w(3, 8'h00));
        checkOutput("s_mem4", 32'(dout_s), 32'h44);
        applyStimulus(1, 1, w(2, 8'h0F));
        applyStimulus(1, 1, w(3, 8'h00));
        checkOutput("s_mem15", 32'(dout_s), 32'h7E);
        applyStimulus(1, 1, w(2, 8'h00));
        applyStimulus(1, 1, w(3, 8'h00));
        checkOutput("s_mem0", 32'(dout_s), 32'h3C);

        // AUTO_INC=0 instance: pointers hold across data commands
        applyStimulus(0, 0, '0);
        checkNoinc("n_rst", 8'h00, 0, 8'h00, 8'h00);
        applyStimulus(1, 1, w(0, 8'h10));
        applyStimulus(1, 1, w(1, 8'h99));
        checkNoinc("n_wr", 8'h00, 0, 8'h10, 8'h00);
        applyStimulus(1, 1, w(2, 8'h10));
        applyStimulus(1, 1, w(3, 8'h00));
        checkNoinc("n_rd1", 8'h99, 1, 8'h10, 8'h10);
        applyStimulus(1, 1, w(3, 8'h00));
        checkNoinc("n_rd2", 8'h99, 1, 8'h10, 8'h10);

        // idle gaps with junk on din
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 0, 10'($urandom));
            checkNoinc($sformatf("idle%0d", k), 8'h99, 0, 8'h10, 8'h10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
